// File: rtl/nios_button_pio.sv
// Avalon-MM input PIO for push-buttons: synchronised levels, per-bit edge capture, maskable irq.
// Optional per-bit debounce filter enabled by defining NIOS_BUTTON_PIO_DEBOUNCE_EN.
module nios_button_pio #(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 1,
  parameter bit IDLE_LEVEL      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [WIDTH-1:0] IDLE_PAT = {WIDTH{IDLE_LEVEL}};

  logic [WIDTH-1:0] sync0_reg, sync1_reg, prev_reg;
  logic [WIDTH-1:0] mask_reg, edgecap_reg;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise, fall, edge_det, w1c;
  logic             wr_en;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0_reg <= IDLE_PAT;
      sync1_reg <= IDLE_PAT;
    end else begin
      sync0_reg <= in_port;
      sync1_reg <= sync0_reg;
    end
  end

`ifdef NIOS_BUTTON_PIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  // Each bit only follows sync1 after it has differed for DEBOUNCE_CYCLES clocks in a row.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_deb
    logic [CW-1:0] cnt_reg;
    logic          stable_reg;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_reg    <= '0;
        stable_reg <= IDLE_LEVEL;
      end else if (sync1_reg[gi] != stable_reg) begin
        if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable_reg <= sync1_reg[gi];
          cnt_reg    <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        cnt_reg <= '0;
      end
    end

    assign stable[gi] = stable_reg;
  end
`else
  assign stable = sync1_reg;
`endif

  assign rise = stable & ~prev_reg;
  assign fall = ~stable & prev_reg;

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_det = rise;
      1:       edge_det = fall;
      default: edge_det = rise | fall;
    endcase
  end

  assign wr_en = chipselect & ~write_n;
  assign w1c   = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_reg    <= IDLE_PAT;
      mask_reg    <= '0;
      edgecap_reg <= '0;
    end else begin
      prev_reg <= stable;
      if (wr_en && address == 2'd2)
        mask_reg <= writedata[WIDTH-1:0];
      // A fresh edge overrides a simultaneous clear of the same bit.
      edgecap_reg <= (edgecap_reg & ~w1c) | edge_det;
    end
  end

  assign irq = |(edgecap_reg & mask_reg);

  always_comb begin
    readdata = '0;
    if (!reset) begin
      case (address)
        2'd0:    readdata[WIDTH-1:0] = stable;
        2'd2:    readdata[WIDTH-1:0] = mask_reg;
        2'd3:    readdata[WIDTH-1:0] = edgecap_reg;
        default: readdata = '0;
      endcase
    end
  end

endmodule
